// File: rtl/seven_seg_scan_controller.sv
// Serial-fed multiplexed 7-segment driver: 2-wire frames in, scanned digits out.
// Ports: clock, resetN (async, low), serialClockIn/serialDataIn (async link),
//   digitOutputPins/segmentOutputPins (scan pins), frameValid/frameError (pulses).
//   Macro BRIGHTNESS_PWM_EN adds input brightness[3:0] that shortens the window.
module seven_seg_scan_controller #(
  parameter int DIGITS           = 4,
  parameter int SEG_W            = 8,
  parameter int ADDR_W           = 2,
  parameter int SCAN_DIV         = 24000,
  parameter int BLANK_CYC        = 240,
  parameter int TIMEOUT          = 65535,
  parameter int DIGIT_ACTIVE_LOW = 1
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              serialClockIn,
  input  logic              serialDataIn,
`ifdef BRIGHTNESS_PWM_EN
  input  logic [3:0]        brightness,
`endif
  output logic [DIGITS-1:0] digitOutputPins,
  output logic [SEG_W-1:0]  segmentOutputPins,
  output logic              frameValid,
  output logic              frameError
);

  localparam int FRAME_W = ADDR_W + SEG_W;
  localparam int BC_W    = $clog2(FRAME_W);
  localparam int SL_W    = $clog2(SCAN_DIV);
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int TO_W    = $clog2(TIMEOUT + 1);

  localparam logic [BC_W-1:0]   BC_LAST   = BC_W'(FRAME_W - 1);
  localparam logic [SL_W-1:0]   SLOT_LAST = SL_W'(SCAN_DIV - 1);
  localparam logic [SL_W-1:0]   BLANK_END = SL_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [ADDR_W:0]   ADDR_LIM  = (ADDR_W + 1)'(DIGITS);
  localparam logic [DIGITS-1:0] OFF       =
    (DIGIT_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [1:0]         sck_sync;
  logic [1:0]         sd_sync;
  logic               sck_last;
  logic               strobe;
  logic               bit_in;

  logic [FRAME_W-1:0] shift_q;
  logic [FRAME_W-1:0] frame_next;
  logic [BC_W-1:0]    bit_cnt;
  logic [TO_W-1:0]    to_cnt;
  logic               last_bit;
  logic [ADDR_W-1:0]  addr;
  logic [SEG_W-1:0]   seg;
  logic               addr_ok;

  logic [SEG_W-1:0]   digit_q [DIGITS];

  logic [SL_W-1:0]    slot_q;
  logic [IDX_W-1:0]   idx_q;
  logic               wrap;
  logic               in_window;
  logic [DIGITS-1:0]  sel;
  logic [SEG_W-1:0]   cur_seg;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      sck_sync <= '0;
      sd_sync  <= '0;
      sck_last <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[0], serialClockIn};
      sd_sync  <= {sd_sync[0], serialDataIn};
      sck_last <= sck_sync[1];
    end
  end

  assign strobe = sck_sync[1] & ~sck_last;
  assign bit_in = sd_sync[1];

  always_comb begin
    frame_next = {shift_q[FRAME_W-2:0], bit_in};
    last_bit   = strobe && (bit_cnt == BC_LAST);
    addr       = frame_next[FRAME_W-1 -: ADDR_W];
    seg        = frame_next[SEG_W-1:0];
    addr_ok    = {1'b0, addr} < ADDR_LIM;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      shift_q    <= '0;
      bit_cnt    <= '0;
      to_cnt     <= '0;
      frameValid <= 1'b0;
      frameError <= 1'b0;
    end else begin
      frameValid <= 1'b0;
      frameError <= 1'b0;
      if (strobe) begin
        to_cnt  <= '0;
        shift_q <= frame_next;
        if (last_bit) begin
          bit_cnt    <= '0;
          frameValid <= addr_ok;
          frameError <= ~addr_ok;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (bit_cnt != '0) begin
        // Stalled partial frame: drop it once the link is quiet too long.
        if (to_cnt == TO_LAST) begin
          bit_cnt    <= '0;
          to_cnt     <= '0;
          frameError <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DIGITS; i++) digit_q[i] <= '0;
    end else if (last_bit && addr_ok) begin
      for (int i = 0; i < DIGITS; i++) begin
        if ({1'b0, addr} == (ADDR_W + 1)'(i)) digit_q[i] <= seg;
      end
    end
  end

  assign wrap = (slot_q == SLOT_LAST);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      slot_q <= '0;
      idx_q  <= '0;
    end else begin
      slot_q <= wrap ? '0 : slot_q + 1'b1;
      if (wrap) idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

`ifdef BRIGHTNESS_PWM_EN
  logic [31:0] win_end;
  always_comb begin
    win_end = 32'(BLANK_CYC)
            + (32'(SCAN_DIV - BLANK_CYC) * (32'(brightness) + 32'd1)) / 32'd16;
    in_window = (slot_q >= BLANK_END) && (32'(slot_q) < win_end);
  end
`else
  assign in_window = (slot_q >= BLANK_END);
`endif

  always_comb begin
    sel     = '0;
    cur_seg = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel[i]  = 1'b1;
        cur_seg = digit_q[i];
      end
    end
  end

  // Pins read digit_q live, so a write lands within the current slot.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      digitOutputPins   <= OFF;
      segmentOutputPins <= '0;
    end else begin
      digitOutputPins   <= in_window ? (sel ^ OFF) : OFF;
      segmentOutputPins <= in_window ? cur_seg : '0;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Randomised self-checking bench for seven_seg_scan_controller.
// Reference: slot/digit arithmetic from elapsed cycles plus a digit array.
module tb_seven_seg_scan_controller;

  localparam int DIGITS    = 3;
  localparam int SEG_W     = 8;
  localparam int ADDR_W    = 2;
  localparam int SCAN_DIV  = 16;
  localparam int BLANK_CYC = 2;
  localparam int TIMEOUT   = 500;
  localparam int FRAME_W   = ADDR_W + SEG_W;

  logic              clock = 1'b0;
  logic              resetN = 1'b0;
  logic              sck = 1'b0;
  logic              sd = 1'b0;
  logic [DIGITS-1:0] digitOutputPins;
  logic [SEG_W-1:0]  segmentOutputPins;
  logic              frameValid;
  logic              frameError;
`ifdef BRIGHTNESS_PWM_EN
  logic [3:0]        brightness = 4'hF;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int vcnt = 0;
  int ecnt = 0;
  logic [SEG_W-1:0] mem [DIGITS];

  seven_seg_scan_controller #(
    .DIGITS(DIGITS), .SEG_W(SEG_W), .ADDR_W(ADDR_W),
    .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC),
    .TIMEOUT(TIMEOUT), .DIGIT_ACTIVE_LOW(1)
  ) dut (
    .clock(clock),
    .resetN(resetN),
    .serialClockIn(sck),
    .serialDataIn(sd),
`ifdef BRIGHTNESS_PWM_EN
    .brightness(brightness),
`endif
    .digitOutputPins(digitOutputPins),
    .segmentOutputPins(segmentOutputPins),
    .frameValid(frameValid),
    .frameError(frameError)
  );

  always #5 clock = ~clock;

  always @(posedge clock or negedge resetN)
    if (!resetN) cyc <= 0;
    else cyc <= cyc + 1;

  always @(negedge clock)
    if (resetN) begin
      vcnt = vcnt + int'(frameValid);
      ecnt = ecnt + int'(frameError);
    end

  // After k edges the pins show slot e=k-1: slot position and digit by division.
  function automatic void exp_out(input int k,
                                  output logic [DIGITS-1:0] ep,
                                  output logic [SEG_W-1:0] es);
    int e, s, d;
    logic [DIGITS-1:0] one;
    ep = '1;
    es = '0;
    if (k > 0) begin
      e = k - 1;
      s = e % SCAN_DIV;
      d = (e / SCAN_DIV) % DIGITS;
      if (s >= BLANK_CYC) begin
        one = DIGITS'(1) << d;
        ep  = ~one;
        es  = mem[d];
      end
    end
  endfunction

  task automatic check_scan(input int n);
    logic [DIGITS-1:0] ep;
    logic [SEG_W-1:0] es;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      exp_out(cyc, ep, es);
      total++;
      if ({digitOutputPins, segmentOutputPins} !== {ep, es}) begin
        bad++;
        $display("FAIL scan cyc=%0d pins=%b seg=%h want pins=%b seg=%h",
                 cyc, digitOutputPins, segmentOutputPins, ep, es);
      end
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clock);
    sd = b;
    repeat (3) @(negedge clock);
    sck = 1'b1;
    repeat (3) @(negedge clock);
    sck = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic send_frame(input logic [ADDR_W-1:0] a,
                            input logic [SEG_W-1:0] s);
    logic [FRAME_W-1:0] v;
    v = {a, s};
    for (int i = FRAME_W - 1; i >= 0; i--) send_bit(v[i]);
    repeat (2) @(negedge clock);
    if (int'(a) < DIGITS) mem[a] = s;
  endtask

  task automatic check_counts(input string nm, input int dv, input int de);
    total++;
    if (dv !== 0 || de !== 0) begin
      bad++;
      $display("FAIL %s valid_delta_err=%0d error_delta_err=%0d want 0 0",
               nm, dv, de);
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < DIGITS; i++) mem[i] = '0;
    #12;
    total++;
    if ({digitOutputPins, segmentOutputPins, frameValid, frameError}
        !== {{DIGITS{1'b1}}, {SEG_W{1'b0}}, 2'b00}) begin
      bad++;
      $display("FAIL reset pins=%b seg=%h v=%b e=%b want 111 00 0 0",
               digitOutputPins, segmentOutputPins, frameValid, frameError);
    end
    @(negedge clock);
    resetN = 1'b1;
    check_scan(2 * SCAN_DIV * DIGITS);
  endtask

  task automatic test_frame;
    int v0, e0;
    v0 = vcnt; e0 = ecnt;
    send_frame(2'd2, 8'h5B);
    check_counts("frame_ok", vcnt - v0 - 1, ecnt - e0);
    check_scan(SCAN_DIV * DIGITS);
  endtask

  task automatic test_bad_addr;
    int v0, e0;
    v0 = vcnt; e0 = ecnt;
    send_frame(2'd3, 8'hA5);
    check_counts("bad_addr", vcnt - v0, ecnt - e0 - 1);
    check_scan(SCAN_DIV * DIGITS);
  endtask

  task automatic test_timeout;
    int v0, e0;
    v0 = vcnt; e0 = ecnt;
    for (int i = 0; i < 5; i++) send_bit(1'($urandom));
    repeat (TIMEOUT + 100) @(negedge clock);
    check_counts("timeout", vcnt - v0, ecnt - e0 - 1);
    send_frame(2'd0, 8'h3F);
    check_counts("after_timeout", vcnt - v0 - 1, ecnt - e0 - 1);
    check_scan(SCAN_DIV * DIGITS);
  endtask

  task automatic test_random;
    int v0, e0, ev, ee;
    logic [ADDR_W-1:0] a;
    logic [SEG_W-1:0] s;
    v0 = vcnt; e0 = ecnt; ev = 0; ee = 0;
    for (int n = 0; n < 10; n++) begin
      a = ADDR_W'($urandom_range(0, 3));
      s = SEG_W'($urandom);
      if (int'(a) < DIGITS) ev++;
      else ee++;
      send_frame(a, s);
      check_scan(SCAN_DIV);
    end
    check_counts("random", vcnt - v0 - ev, ecnt - e0 - ee);
    check_scan(SCAN_DIV * DIGITS);
  endtask

  // Pins follow the final serial rise by two sync stages plus strobe->reg->pin.
  task automatic test_live_write;
    logic [FRAME_W-1:0] v;
    logic found;
    int v0;
    send_frame(2'd1, 8'hFF);
    v0 = vcnt;
    v = {2'd1, 8'h06};
    for (int i = FRAME_W - 1; i >= 1; i--) send_bit(v[i]);
    sd = v[0];
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clock);
      if (cyc >= 1 && (cyc - 1) % SCAN_DIV == 2
          && ((cyc - 1) / SCAN_DIV) % DIGITS == 1) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL live_wait no digit1 slot within 200 cycles");
    end else begin
      sck = 1'b1;
      repeat (3) @(negedge clock);
      total++;
      if ({digitOutputPins, segmentOutputPins} !== {3'b101, 8'hFF}) begin
        bad++;
        $display("FAIL live_old pins=%b seg=%h want 101 ff",
                 digitOutputPins, segmentOutputPins);
      end
      @(negedge clock);
      if ({digitOutputPins, segmentOutputPins} !== {3'b101, 8'h06}) begin
        bad++;
        $display("FAIL live_new pins=%b seg=%h want 101 06",
                 digitOutputPins, segmentOutputPins);
      end
      sck = 1'b0;
      repeat (3) @(negedge clock);
      mem[1] = 8'h06;
    end
    check_counts("live_valid", vcnt - v0 - 1, 0);
    check_scan(SCAN_DIV * DIGITS);
  endtask

  task automatic test_reset_mid;
    int v0, e0;
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (7) @(negedge clock);
    v0 = vcnt; e0 = ecnt;
    #2 resetN = 1'b0;
    #1;
    total++;
    if ({digitOutputPins, segmentOutputPins, frameValid, frameError}
        !== {{DIGITS{1'b1}}, {SEG_W{1'b0}}, 2'b00}) begin
      bad++;
      $display("FAIL reset_mid pins=%b seg=%h v=%b e=%b want 111 00 0 0",
               digitOutputPins, segmentOutputPins, frameValid, frameError);
    end
    for (int i = 0; i < DIGITS; i++) mem[i] = '0;
    @(negedge clock);
    @(negedge clock);
    resetN = 1'b1;
    check_scan(SCAN_DIV * DIGITS);
    send_frame(2'd2, 8'h3C);
    check_counts("reset_mid", vcnt - v0 - 1, ecnt - e0);
    check_scan(SCAN_DIV * DIGITS);
  endtask

  initial begin
    test_reset;
    test_frame;
    test_bad_addr;
    test_timeout;
    test_random;
    test_live_write;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
